// File: rtl/peripheral_bus_arbiter_pkg.sv
// Shared widths, FSM encoding and request bundle for peripheral_bus_arbiter.
package peripheral_bus_arbiter_pkg;

    localparam int BUS_ADDR_W = 24;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_SEL_W  = 4;
    localparam int TMO_CNT_W  = 8;

    localparam logic [BUS_DATA_W-1:0] BUS_DATA_IDLE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                  we;
        logic                  oe;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_SEL_W-1:0]  sel;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/peripheral_bus_timeout.sv
// Stall watchdog for a granted transfer: counts busy cycles of one grant.
module peripheral_bus_timeout
    import peripheral_bus_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic busy_i,
    output logic hit_o
);

    localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(LIMIT - 1);

    logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!active_i) begin
            cnt_d = '0;
        end else if (busy_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The cycle that would make the count reach LIMIT is the forced completion.
    assign hit_o = active_i & busy_i & (cnt_q == LAST);

endmodule

// File: rtl/peripheral_bus_arbiter.sv
// Round-robin two-master arbiter for the 24-bit peripheral bus.
// Optional stall timeout: define PERIPHERAL_BUS_ARBITER_TIMEOUT_EN.
module peripheral_bus_arbiter
    import peripheral_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_we,
    input  logic                  m1_we,
    input  logic                  m0_oe,
    input  logic                  m1_oe,
    input  logic [BUS_ADDR_W-1:0] m0_address,
    input  logic [BUS_ADDR_W-1:0] m1_address,
    input  logic [BUS_SEL_W-1:0]  m0_byteSelect,
    input  logic [BUS_SEL_W-1:0]  m1_byteSelect,
    input  logic [BUS_DATA_W-1:0] m0_dataWrite,
    input  logic [BUS_DATA_W-1:0] m1_dataWrite,
    output logic [BUS_DATA_W-1:0] m0_dataRead,
    output logic [BUS_DATA_W-1:0] m1_dataRead,
    output logic                  m0_busy,
    output logic                  m1_busy,
    output logic                  peripheralBus_we,
    output logic                  peripheralBus_oe,
    output logic [BUS_ADDR_W-1:0] peripheralBus_address,
    output logic [BUS_SEL_W-1:0]  peripheralBus_byteSelect,
    output logic [BUS_DATA_W-1:0] peripheralBus_dataWrite,
    input  logic                  peripheralBus_busy,
    input  logic [BUS_DATA_W-1:0] peripheralBus_dataRead,
    input  logic                  requestOutput,
    output logic                  timeout_irq
);

    arb_state_e state_q, state_d;
    logic       rr_q, rr_d;

    logic       req0, req1;
    logic       gnt0, gnt1;
    logic       gnt_end;
    logic       tmo_hit;
    bus_req_t   m0_r, m1_r, bus_r;
    logic [BUS_DATA_W-1:0] rdata;

    assign req0 = m0_we | m0_oe;
    assign req1 = m1_we | m1_oe;
    assign gnt0 = (state_q == ARB_GRANT0);
    assign gnt1 = (state_q == ARB_GRANT1);

    // A combined we+oe request is a write, so oe is masked by we.
    assign m0_r = '{we: m0_we, oe: m0_oe & ~m0_we, addr: m0_address,
                    sel: m0_byteSelect, wdata: m0_dataWrite};
    assign m1_r = '{we: m1_we, oe: m1_oe & ~m1_we, addr: m1_address,
                    sel: m1_byteSelect, wdata: m1_dataWrite};

    always_comb begin
        bus_r = '0;
        if (gnt0) begin
            bus_r = m0_r;
        end else if (gnt1) begin
            bus_r = m1_r;
        end
    end

    assign peripheralBus_we         = bus_r.we;
    assign peripheralBus_oe         = bus_r.oe;
    assign peripheralBus_address    = bus_r.addr;
    assign peripheralBus_byteSelect = bus_r.sel;
    assign peripheralBus_dataWrite  = bus_r.wdata;

`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
    peripheral_bus_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .active_i (gnt0 | gnt1),
        .busy_i   (peripheralBus_busy),
        .hit_o    (tmo_hit)
    );
`else
    logic [TMO_CNT_W-1:0] tmo_limit_unused;
    assign tmo_limit_unused = TMO_CNT_W'(TIMEOUT_CYCLES);
    assign tmo_hit          = 1'b0;
`endif

    assign timeout_irq = tmo_hit;

    assign gnt_end = (gnt0 & ~req0) | (gnt1 & ~req1)
                   | ((gnt0 | gnt1) & (~peripheralBus_busy | tmo_hit));

    assign rdata = requestOutput ? peripheralBus_dataRead : BUS_DATA_IDLE;

    assign m0_busy = gnt0 ? (peripheralBus_busy & ~tmo_hit) : (gnt1 | req0);
    assign m1_busy = gnt1 ? (peripheralBus_busy & ~tmo_hit) : (gnt0 | req1);

    assign m0_dataRead = (gnt0 & ~peripheralBus_busy) ? rdata : BUS_DATA_IDLE;
    assign m1_dataRead = (gnt1 & ~peripheralBus_busy) ? rdata : BUS_DATA_IDLE;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (req0 && (!req1 || !rr_q)) begin
                    state_d = ARB_GRANT0;
                end else if (req1) begin
                    state_d = ARB_GRANT1;
                end
            end
            ARB_GRANT0, ARB_GRANT1: begin
                if (gnt_end) begin
                    state_d = ARB_IDLE;
                    rr_d    = gnt0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Bench for peripheral_bus_arbiter: vector table, corner sequences, random vs model.
module tb_peripheral_bus_arbiter;

    localparam logic [31:0] FF = 32'hFFFF_FFFF;

`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int MAIN_LIMIT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_we, m1_we, m0_oe, m1_oe;
    logic [23:0] m0_address, m1_address;
    logic [3:0]  m0_byteSelect, m1_byteSelect;
    logic [31:0] m0_dataWrite, m1_dataWrite;
    logic [31:0] m0_dataRead, m1_dataRead;
    logic        m0_busy, m1_busy;
    logic        peripheralBus_we, peripheralBus_oe;
    logic [23:0] peripheralBus_address;
    logic [3:0]  peripheralBus_byteSelect;
    logic [31:0] peripheralBus_dataWrite;
    logic        peripheralBus_busy;
    logic [31:0] peripheralBus_dataRead;
    logic        requestOutput;
    logic        timeout_irq;

    int errors = 0;
    int checks = 0;

    peripheral_bus_arbiter dut (
        .clk                      (clk),
        .rst                      (rst),
        .m0_we                    (m0_we),
        .m1_we                    (m1_we),
        .m0_oe                    (m0_oe),
        .m1_oe                    (m1_oe),
        .m0_address               (m0_address),
        .m1_address               (m1_address),
        .m0_byteSelect            (m0_byteSelect),
        .m1_byteSelect            (m1_byteSelect),
        .m0_dataWrite             (m0_dataWrite),
        .m1_dataWrite             (m1_dataWrite),
        .m0_dataRead              (m0_dataRead),
        .m1_dataRead              (m1_dataRead),
        .m0_busy                  (m0_busy),
        .m1_busy                  (m1_busy),
        .peripheralBus_we         (peripheralBus_we),
        .peripheralBus_oe         (peripheralBus_oe),
        .peripheralBus_address    (peripheralBus_address),
        .peripheralBus_byteSelect (peripheralBus_byteSelect),
        .peripheralBus_dataWrite  (peripheralBus_dataWrite),
        .peripheralBus_busy       (peripheralBus_busy),
        .peripheralBus_dataRead   (peripheralBus_dataRead),
        .requestOutput            (requestOutput),
        .timeout_irq              (timeout_irq)
    );

`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
    logic        t_b0, t_b1, t_we, t_oe, t_irq;
    logic [31:0] t_d0, t_d1, t_wd;
    logic [23:0] t_addr;
    logic [3:0]  t_sel;

    peripheral_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk                      (clk),
        .rst                      (rst),
        .m0_we                    (m0_we),
        .m1_we                    (m1_we),
        .m0_oe                    (m0_oe),
        .m1_oe                    (m1_oe),
        .m0_address               (m0_address),
        .m1_address               (m1_address),
        .m0_byteSelect            (m0_byteSelect),
        .m1_byteSelect            (m1_byteSelect),
        .m0_dataWrite             (m0_dataWrite),
        .m1_dataWrite             (m1_dataWrite),
        .m0_dataRead              (t_d0),
        .m1_dataRead              (t_d1),
        .m0_busy                  (t_b0),
        .m1_busy                  (t_b1),
        .peripheralBus_we         (t_we),
        .peripheralBus_oe         (t_oe),
        .peripheralBus_address    (t_addr),
        .peripheralBus_byteSelect (t_sel),
        .peripheralBus_dataWrite  (t_wd),
        .peripheralBus_busy       (peripheralBus_busy),
        .peripheralBus_dataRead   (peripheralBus_dataRead),
        .requestOutput            (requestOutput),
        .timeout_irq              (t_irq)
    );
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic        rs, w0, o0, w1, o1, pb, ro;
        logic [31:0] pd;
        logic        eb0, eb1;
        logic [31:0] ed0, ed1;
        logic        ewe, eoe;
        int          eown;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic rs, input logic w0, input logic o0,
        input logic w1, input logic o1, input logic pb,
        input logic ro, input logic [31:0] pd,
        input logic eb0, input logic eb1,
        input logic [31:0] ed0, input logic [31:0] ed1,
        input logic ewe, input logic eoe, input int eown);
        vec_t v;
        v.rs = rs; v.w0 = w0; v.o0 = o0; v.w1 = w1; v.o1 = o1;
        v.pb = pb; v.ro = ro; v.pd = pd;
        v.eb0 = eb0; v.eb1 = eb1; v.ed0 = ed0; v.ed1 = ed1;
        v.ewe = ewe; v.eoe = eoe; v.eown = eown;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_main(input string tag,
                              input logic eb0, input logic eb1,
                              input logic [31:0] ed0, input logic [31:0] ed1,
                              input logic ewe, input logic eoe,
                              input int eown, input logic eirq);
        logic [23:0] ea;
        logic [3:0]  es;
        logic [31:0] ew;
        ea = (eown == 0) ? m0_address : (eown == 1) ? m1_address : 24'h0;
        es = (eown == 0) ? m0_byteSelect : (eown == 1) ? m1_byteSelect : 4'h0;
        ew = (eown == 0) ? m0_dataWrite : (eown == 1) ? m1_dataWrite : 32'h0;
        chk({tag, ".m0_busy"}, 32'(m0_busy), 32'(eb0));
        chk({tag, ".m1_busy"}, 32'(m1_busy), 32'(eb1));
        chk({tag, ".m0_dataRead"}, m0_dataRead, ed0);
        chk({tag, ".m1_dataRead"}, m1_dataRead, ed1);
        chk({tag, ".bus_we"}, 32'(peripheralBus_we), 32'(ewe));
        chk({tag, ".bus_oe"}, 32'(peripheralBus_oe), 32'(eoe));
        chk({tag, ".bus_addr"}, 32'(peripheralBus_address), 32'(ea));
        chk({tag, ".bus_sel"}, 32'(peripheralBus_byteSelect), 32'(es));
        chk({tag, ".bus_wdata"}, peripheralBus_dataWrite, ew);
        chk({tag, ".irq"}, 32'(timeout_irq), 32'(eirq));
    endtask

    task automatic drive(input logic w0, input logic o0, input logic w1,
                         input logic o1, input logic pb, input logic ro,
                         input logic [31:0] pd);
        m0_we = w0; m0_oe = o0; m1_we = w1; m1_oe = o1;
        peripheralBus_busy = pb; requestOutput = ro;
        peripheralBus_dataRead = pd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        repeat (2) step();
        rst = 1'b0;
    endtask

    // Reference model state: owner -1 = bus idle.
    int owner, rr, run;

    initial begin
        m0_address = 24'h030010; m1_address = 24'h040020;
        m0_byteSelect = 4'hF;    m1_byteSelect = 4'h3;
        m0_dataWrite = 32'h1111_2222; m1_dataWrite = 32'hDEAD_BEEF;
        do_reset();

        vt.push_back(mk(0, 0,0,0,0, 0,0,32'h0, 0,0,FF,FF, 0,0,2));
        vt.push_back(mk(0, 1,0,1,0, 0,0,32'h0, 1,1,FF,FF, 0,0,2));
        vt.push_back(mk(0, 1,0,1,0, 0,0,32'h0, 0,1,FF,FF, 1,0,0));
        vt.push_back(mk(0, 0,0,1,0, 0,0,32'h0, 0,1,FF,FF, 0,0,2));
        vt.push_back(mk(0, 0,0,1,0, 0,0,32'h0, 1,0,FF,FF, 1,0,1));
        vt.push_back(mk(0, 0,0,0,0, 0,0,32'h0, 0,0,FF,FF, 0,0,2));
        vt.push_back(mk(0, 0,1,0,0, 0,0,32'h0, 1,0,FF,FF, 0,0,2));
        vt.push_back(mk(0, 0,1,0,0, 0,1,32'hA5, 0,1,32'hA5,FF, 0,1,0));
        vt.push_back(mk(0, 0,0,0,0, 0,0,32'h0, 0,0,FF,FF, 0,0,2));
        vt.push_back(mk(0, 0,0,0,1, 0,0,32'h0, 0,1,FF,FF, 0,0,2));
        for (int k = 0; k < 5; k++)
            vt.push_back(mk(0, 0,0,0,1, 1,0,32'h0, 1,1,FF,FF, 0,1,1));
        vt.push_back(mk(0, 0,0,0,1, 0,1,32'h1234_5678,
                        1,0,FF,32'h1234_5678, 0,1,1));
        vt.push_back(mk(0, 0,0,0,0, 0,0,32'h0, 0,0,FF,FF, 0,0,2));
        vt.push_back(mk(0, 0,1,0,0, 0,0,32'h0, 1,0,FF,FF, 0,0,2));
        vt.push_back(mk(0, 0,1,0,0, 0,0,32'h5555_AAAA, 0,1,FF,FF, 0,1,0));
        vt.push_back(mk(0, 0,0,0,0, 0,0,32'h0, 0,0,FF,FF, 0,0,2));
        vt.push_back(mk(0, 0,1,0,0, 0,0,32'h0, 1,0,FF,FF, 0,0,2));
        vt.push_back(mk(0, 0,1,0,1, 1,0,32'h0, 1,1,FF,FF, 0,1,0));
        vt.push_back(mk(0, 0,0,0,1, 1,0,32'h0, 1,1,FF,FF, 0,0,0));
        vt.push_back(mk(0, 0,0,0,1, 1,0,32'h0, 0,1,FF,FF, 0,0,2));
        vt.push_back(mk(0, 0,0,0,1, 0,1,32'hCAFE_F00D,
                        1,0,FF,32'hCAFE_F00D, 0,1,1));
        vt.push_back(mk(0, 0,0,0,0, 0,0,32'h0, 0,0,FF,FF, 0,0,2));
        vt.push_back(mk(0, 1,1,0,0, 0,0,32'h0, 1,0,FF,FF, 0,0,2));
        vt.push_back(mk(0, 1,1,0,0, 0,0,32'h0, 0,1,FF,FF, 1,0,0));
        vt.push_back(mk(0, 0,0,0,0, 0,0,32'h0, 0,0,FF,FF, 0,0,2));
        vt.push_back(mk(0, 0,1,0,0, 0,0,32'h0, 1,0,FF,FF, 0,0,2));
        vt.push_back(mk(0, 0,1,0,0, 1,0,32'h0, 1,1,FF,FF, 0,1,0));
        vt.push_back(mk(1, 0,1,0,0, 1,0,32'h0, 1,1,FF,FF, 0,1,0));
        vt.push_back(mk(0, 0,1,0,0, 1,0,32'h0, 1,0,FF,FF, 0,0,2));
        vt.push_back(mk(0, 0,1,0,0, 0,1,32'h0BAD_F00D,
                        0,1,32'h0BAD_F00D,FF, 0,1,0));
        vt.push_back(mk(0, 0,0,0,0, 0,0,32'h0, 0,0,FF,FF, 0,0,2));
        vt.push_back(mk(0, 1,0,1,0, 0,0,32'h0, 1,1,FF,FF, 0,0,2));
        vt.push_back(mk(0, 1,0,1,0, 0,0,32'h0, 1,0,FF,FF, 1,0,1));
        vt.push_back(mk(0, 1,0,1,0, 0,0,32'h0, 1,1,FF,FF, 0,0,2));
        vt.push_back(mk(0, 1,0,1,0, 0,0,32'h0, 0,1,FF,FF, 1,0,0));
        vt.push_back(mk(0, 1,0,1,0, 0,0,32'h0, 1,1,FF,FF, 0,0,2));
        vt.push_back(mk(0, 1,0,1,0, 0,0,32'h0, 1,0,FF,FF, 1,0,1));
        vt.push_back(mk(0, 0,0,0,0, 0,0,32'h0, 0,0,FF,FF, 0,0,2));

        foreach (vt[i]) begin
            rst = vt[i].rs;
            drive(vt[i].w0, vt[i].o0, vt[i].w1, vt[i].o1,
                  vt[i].pb, vt[i].ro, vt[i].pd);
            #3;
            check_main($sformatf("vec%0d", i), vt[i].eb0, vt[i].eb1,
                       vt[i].ed0, vt[i].ed1, vt[i].ewe, vt[i].eoe,
                       vt[i].eown, 1'b0);
            step();
        end
        rst = 1'b0;

        do_reset();
`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
        drive(0, 1, 0, 1, 0, 0, 32'h0); #3;
        chk("to.req.m0_busy", 32'(t_b0), 32'd1);
        chk("to.req.irq", 32'(t_irq), 32'd0);
        step();
        for (int k = 1; k <= 3; k++) begin
            drive(0, 1, 0, 1, 1, 0, 32'h0); #3;
            chk($sformatf("to.stall%0d.m0_busy", k), 32'(t_b0), 32'd1);
            chk($sformatf("to.stall%0d.oe", k), 32'(t_oe), 32'd1);
            chk($sformatf("to.stall%0d.irq", k), 32'(t_irq), 32'd0);
            step();
        end
        drive(0, 1, 0, 1, 1, 1, 32'h1234); #3;
        chk("to.hit.m0_busy", 32'(t_b0), 32'd0);
        chk("to.hit.m0_dataRead", t_d0, FF);
        chk("to.hit.irq", 32'(t_irq), 32'd1);
        chk("to.hit.m1_busy", 32'(t_b1), 32'd1);
        step();
        drive(0, 0, 0, 1, 1, 0, 32'h0); #3;
        chk("to.idle.irq", 32'(t_irq), 32'd0);
        chk("to.idle.oe", 32'(t_oe), 32'd0);
        chk("to.idle.m1_busy", 32'(t_b1), 32'd1);
        step();
        drive(0, 0, 0, 1, 0, 1, 32'h77); #3;
        chk("to.next.m1_busy", 32'(t_b1), 32'd0);
        chk("to.next.m1_dataRead", t_d1, 32'h77);
        chk("to.next.oe", 32'(t_oe), 32'd1);
        chk("to.next.addr", 32'(t_addr), 32'(m1_address));
        step();
`else
        drive(0, 1, 0, 0, 0, 0, 32'h0); #3;
        check_main("nto.req", 1, 0, FF, FF, 0, 0, 2, 0);
        step();
        for (int k = 0; k < 20; k++) begin
            drive(0, 1, 0, 0, 1, 0, 32'h0); #3;
            chk($sformatf("nto.stall%0d.m0_busy", k), 32'(m0_busy), 32'd1);
            chk($sformatf("nto.stall%0d.irq", k), 32'(timeout_irq), 32'd0);
            step();
        end
        drive(0, 1, 0, 0, 0, 1, 32'h5A5A); #3;
        check_main("nto.done", 0, 1, 32'h5A5A, FF, 0, 1, 0, 0);
        step();
`endif

        do_reset();
        owner = -1; rr = 0; run = 0;
        for (int c = 0; c < 600; c++) begin
            logic w[2], o[2], rq[2], to;
            logic eb[2], ewe, eoe, eirq;
            logic [31:0] ed[2];
            int eown;
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom);
            m0_address = 24'($urandom); m1_address = 24'($urandom);
            m0_byteSelect = 4'($urandom); m1_byteSelect = 4'($urandom);
            m0_dataWrite = $urandom; m1_dataWrite = $urandom;
            w[0] = m0_we; w[1] = m1_we; o[0] = m0_oe; o[1] = m1_oe;
            rq[0] = w[0] | o[0]; rq[1] = w[1] | o[1];
            to = 1'b0;
            ed[0] = FF; ed[1] = FF; ewe = 0; eoe = 0; eirq = 0; eown = 2;
            if (owner < 0) begin
                eb[0] = rq[0]; eb[1] = rq[1];
            end else begin
                to = TO_EN && peripheralBus_busy && (run + 1 >= MAIN_LIMIT);
                eown = owner;
                eb[1 - owner] = 1'b1;
                eb[owner] = peripheralBus_busy && !to;
                if (!peripheralBus_busy && requestOutput)
                    ed[owner] = peripheralBus_dataRead;
                ewe = w[owner]; eoe = o[owner] && !w[owner];
                eirq = to;
            end
            #3;
            check_main($sformatf("rnd%0d", c), eb[0], eb[1], ed[0], ed[1],
                       ewe, eoe, eown, eirq);
            if (owner < 0) begin
                if (rq[0] && rq[1]) owner = rr;
                else if (rq[0]) owner = 0;
                else if (rq[1]) owner = 1;
                run = 0;
            end else if (!peripheralBus_busy || to || !rq[owner]) begin
                rr = 1 - owner;
                owner = -1;
            end else begin
                run++;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/peripheral_bus_arbiter.md
# peripheral_bus_arbiter

Two-master arbiter for the 24-bit peripheral bus that feeds GPIO and the other peripheral slaves. It grants the single shared bus to one master at a time with round-robin fairness. It holds the grant until the addressed slave drops busy, then routes read data and completion back to the granted master. It sits between the core/DMA bus bridges and the peripheral slaves; slave `dataRead` and `requestOutput` are already OR/muxed upstream.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: max cycles a granted transfer may stay busy; range 1..255.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `m0_we`, `m1_we` in 1: master write request.
- `m0_oe`, `m1_oe` in 1: master read request.
- `m0_address`, `m1_address` in 24: master address.
- `m0_byteSelect`, `m1_byteSelect` in 4: master byte lanes.
- `m0_dataWrite`, `m1_dataWrite` in 32: master write data.
- `m0_dataRead`, `m1_dataRead` out 32: read data to master.
- `m0_busy`, `m1_busy` out 1: master must hold its request while high.
- `peripheralBus_we`, `peripheralBus_oe` out 1: to slaves.
- `peripheralBus_address` out 24: to slaves.
- `peripheralBus_byteSelect` out 4: to slaves.
- `peripheralBus_dataWrite` out 32: to slaves.
- `peripheralBus_busy` in 1: slave stall.
- `peripheralBus_dataRead` in 32: slave read data.
- `requestOutput` in 1: a slave claims the read.
- `timeout_irq` out 1: one-cycle pulse on a timeout abort.

## Operation
- Request from master n: `mn_we | mn_oe`. If both `we` and `oe` are high, the access is treated as a write.
- FSM states:
  - IDLE → GRANT0/GRANT1 on any request.
  - GRANTn → IDLE on completion, timeout abort, or `mn` dropping its request (abort, no response).
- Arbitration in IDLE:
  - Only one master requesting: that master wins.
  - Both requesting: the master indicated by `rr_ptr` wins.
  - `rr_ptr` is set to the other master on every completion or abort.
- In GRANTn:
  - Bus outputs are a combinational copy of master n's signals.
  - The non-granted master sees `busy=1` and `dataRead=~0`.
- Completion: a GRANTn cycle with `peripheralBus_busy=0`.
  - Master n sees `busy=0` that cycle.
  - Read data is `peripheralBus_dataRead` if `requestOutput`, else `32'hFFFFFFFF`.
- Outside a grant:
  - Both `busy` outputs are 1 whenever the corresponding request is high, else 0.
  - Bus `we`/`oe` = 0, address/byteSelect/dataWrite = 0.
- Reset values:
  - FSM = IDLE, `rr_ptr` = 0 (master 0 wins the first tie), timeout counter = 0.
  - `timeout_irq` = 0, all bus strobes = 0.
  - `mN_dataRead` = `~32'b0`.
- Reset asserted mid-transfer:
  - Bus strobes drop in the next cycle.
  - The master gets no completion; it must re-issue.

## Timing
- Request seen in IDLE at cycle N → grant registered at N+1 → bus strobes driven from N+1.
- Earliest completion is N+1 (master sees `busy` high at N, low at N+1).
- After completion the FSM spends exactly one cycle in IDLE, even if requests are pending.
  - So back-to-back transfers occupy 2 cycles minimum.
  - With both masters streaming, grants alternate 0,1,0,1.
- A new request from the just-completed master is not seen until that IDLE cycle. Masters deassert or change the request in the cycle after seeing `busy=0`.
- No combinational path from `peripheralBus_busy` to bus strobes; only to `mN_busy` and `mN_dataRead`.

## Configuration
- `PERIPHERAL_BUS_ARBITER_TIMEOUT_EN` defined:
  - An 8-bit counter clears on grant and increments every GRANTn cycle with `peripheralBus_busy=1`.
  - When it reaches `TIMEOUT_CYCLES`, that cycle is a forced completion: master `busy=0`, `dataRead=~0`, `timeout_irq=1`.
  - The FSM then goes to IDLE and `rr_ptr` flips.
- Undefined:
  - No counter is built; `timeout_irq` is tied 0.
  - A grant is held until completion or request drop, indefinitely.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2).
  - `BUS_ADDR_W=24`, `BUS_DATA_W=32`, `BUS_SEL_W=4`.
  - `BUS_DATA_IDLE=32'hFFFFFFFF`.
- One natural sub-module: `peripheral_bus_timeout` (counter plus compare). It is instantiated only under the macro.

## Test plan
- Single master: m0 read at address `24'h030010`, slave busy 0, `requestOutput=1`, data `32'h0000_00A5` → m0 `busy` high 1 cycle, then low with `dataRead=32'h000000A5`; bus `oe` high exactly 1 cycle.
- Tie after reset: m0 and m1 write in the same cycle → m0 granted first. m1 held busy; it is granted after 1 idle cycle. Its `dataWrite` (`32'hDEADBEEF`) appears on the bus.
- Slave stall: granted m1 read, slave busy for 5 cycles → m1 `busy` stays high 6 cycles total after the grant. Data is accepted in the cycle busy falls.
- Unclaimed read: `requestOutput=0` at completion → `dataRead=32'hFFFFFFFF`.
- Abort: m0 drops its request mid-stall → FSM returns to IDLE next cycle, bus strobes drop, and pending m1 is granted after 1 idle cycle.
- Timeout (macro on, `TIMEOUT_CYCLES=4`): slave busy stuck → forced completion on the 4th busy cycle. Expect `timeout_irq` 1-cycle pulse, `dataRead=~0`, and the other master granted next.
